// File: rtl/config_loader.sv
// config_loader: streams host bytes MSB-first into a scan chain and returns the bits shifted out as readback bytes.
module config_loader #(
  parameter int CHAIN_LENGTH = 64,
  parameter int CNT_WIDTH    = 16
) (
  input  logic       scan_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       chain_in,
  output logic       scan_en,
  input  logic       chain_out,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [CNT_WIDTH-1:0] LEN = CNT_WIDTH'(CHAIN_LENGTH);
  localparam int PAD = (8 - CHAIN_LENGTH % 8) % 8;
  logic [1:0] state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d, rem;
  logic [3:0] nbits_q, nbits_d;
  logic [7:0] shreg_q, shreg_d, rb_q, rb_d, rd_data_q, rd_data_d;
  logic rd_valid_q, rd_valid_d, scan_en_q, scan_en_d, chain_in_q, chain_in_d;
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    nbits_d    = nbits_q;
    shreg_d    = shreg_q;
    rb_d       = rb_q;
    rd_data_d  = '0;
    rd_valid_d = 1'b0;
    rem        = LEN - count_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        count_d = '0;
      end
      FETCH: if (in_valid) begin
        shreg_d = in_data;
        nbits_d = rem >= CNT_WIDTH'(8) ? 4'd8 : rem[3:0];
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {shreg_q[6:0], 1'b0};
        count_d = count_q + 1'b1;
        rb_d    = {rb_q[6:0], chain_out};
        nbits_d = nbits_q - 4'd1;
        if (nbits_q == 4'd1) begin
          // only the final byte of a load can be short, so it alone needs left-aligning
          rd_valid_d = 1'b1;
          rd_data_d  = count_d == LEN ? rb_d << PAD : rb_d;
          state_d    = count_d == LEN ? DONE : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    scan_en_d  = state_d == SHIFT;
    chain_in_d = scan_en_d & shreg_d[7];
  end
  always_ff @(posedge scan_clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      nbits_q    <= '0;
      shreg_q    <= '0;
      rb_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      scan_en_q  <= 1'b0;
      chain_in_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      nbits_q    <= nbits_d;
      shreg_q    <= shreg_d;
      rb_q       <= rb_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      scan_en_q  <= scan_en_d;
      chain_in_q <= chain_in_d;
    end
  end
  assign in_ready = state_q == FETCH;
  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign scan_en  = scan_en_q;
  assign chain_in = chain_in_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_config_loader.sv
// tb_config_loader: scoreboard bench driving a 16-bit and a 12-bit chain loader against behavioural chain models.
module tb_config_loader;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_v, in_valid_v, in_ready_v, chain_in_v, scan_en_v, chain_out_v, rd_valid_v, busy_v, done_v;
  logic [7:0] in_data_v [2];
  logic [7:0] rd_data_v [2];
  logic [15:0] chain16 = '0;
  logic [11:0] chain12 = '0;
  logic [15:0] pre16;
  logic [11:0] pre12;
  logic [1:0] pre_en;
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [15:0] seq [2];
  int sc_cnt [2];
  int done_cnt [2];
  int done_cyc [2];
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  config_loader #(.CHAIN_LENGTH(16), .CNT_WIDTH(16)) u16 (
    .scan_clk(clk), .rst(rst), .start(start_v[0]), .in_data(in_data_v[0]), .in_valid(in_valid_v[0]),
    .in_ready(in_ready_v[0]), .chain_in(chain_in_v[0]), .scan_en(scan_en_v[0]), .chain_out(chain_out_v[0]),
    .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  config_loader #(.CHAIN_LENGTH(12), .CNT_WIDTH(16)) u12 (
    .scan_clk(clk), .rst(rst), .start(start_v[1]), .in_data(in_data_v[1]), .in_valid(in_valid_v[1]),
    .in_ready(in_ready_v[1]), .chain_in(chain_in_v[1]), .scan_en(scan_en_v[1]), .chain_out(chain_out_v[1]),
    .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  // chain cells: shift toward the far end whenever scan_en is high
  always @(posedge clk) begin
    if (pre_en[0]) chain16 <= pre16;
    else if (scan_en_v[0]) chain16 <= {chain16[14:0], chain_in_v[0]};
    if (pre_en[1]) chain12 <= pre12;
    else if (scan_en_v[1]) chain12 <= {chain12[10:0], chain_in_v[1]};
  end
  assign chain_out_v = {chain12[11], chain16[15]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (scan_en_v[s]) begin
        sc_cnt[s]++;
        seq[s] = {seq[s][14:0], chain_in_v[s]};
      end
      if (done_v[s]) begin
        done_cnt[s]++;
        done_cyc[s] = cyc;
      end
      if (rd_valid_v[s]) begin
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) chk("rd_unexpected", 32'(rd_valid_v[s]), 0);
        else chk("rd_data", 32'(rd_data_v[s]), 32'(s == 0 ? q0.pop_front() : q1.pop_front()));
      end
    end
  end

  task automatic preload(input int s, input logic [15:0] v);
    pre16 = v;
    pre12 = v[11:0];
    pre_en[s] = 1'b1;
    @(negedge clk);
    pre_en[s] = 1'b0;
  endtask

  task automatic send(input int s, input logic [7:0] b);
    int n = 0;
    in_data_v[s] = b;
    in_valid_v[s] = 1'b1;
    while (!in_ready_v[s] && n < 200) begin @(negedge clk); n++; end
    chk("in_ready_wait", 32'(in_ready_v[s]), 1);
    @(negedge clk);
  endtask

  task automatic load(input int s, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] e0,
                      input logic [7:0] e1, input logic [15:0] eseq, input int elen, input int ecyc,
                      input int stall, input bit poke);
    int bsc, bdn, t0, n;
    logic [15:0] m;
    bsc = sc_cnt[s];
    bdn = done_cnt[s];
    if (s == 0) begin q0.push_back(e0); q0.push_back(e1); end
    else begin q1.push_back(e0); q1.push_back(e1); end
    start_v[s] = 1'b1;
    in_data_v[s] = b0;
    in_valid_v[s] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_v[s] = 1'b0;
    send(s, b0);
    if (poke) begin
      start_v[s] = 1'b1;
      @(negedge clk);
      start_v[s] = 1'b0;
    end
    if (stall > 0) begin
      in_valid_v[s] = 1'b0;
      n = 0;
      while (!in_ready_v[s] && n < 200) begin @(negedge clk); n++; end
      repeat (stall) begin
        @(negedge clk);
        chk("stall_scan_en", 32'(scan_en_v[s]), 0);
      end
    end
    send(s, b1);
    in_valid_v[s] = 1'b0;
    n = 0;
    while (done_cnt[s] == bdn && n < 200) begin @(negedge clk); n++; end
    chk("done_latency", done_cyc[s] - t0, ecyc);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt[s] - bdn, 1);
    chk("scan_cycles", sc_cnt[s] - bsc, elen);
    m = 16'((32'h1 << elen) - 1);
    chk("chain_in_seq", 32'(seq[s] & m), 32'(eseq));
    chk("chain_out_first", 32'(chain_out_v[s]), 32'(eseq[elen-1]));
  endtask

  initial begin
    int bsc, n;
    rst = 1'b1;
    start_v = '0;
    in_valid_v = '0;
    in_data_v[0] = '0;
    in_data_v[1] = '0;
    pre_en = '0;
    pre16 = '0;
    pre12 = '0;
    for (int s = 0; s < 2; s++) begin
      seq[s] = '0; sc_cnt[s] = 0; done_cnt[s] = 0; done_cyc[s] = 0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++)
      chk("reset_outputs", {in_ready_v[s], scan_en_v[s], chain_in_v[s], rd_valid_v[s], busy_v[s], done_v[s], rd_data_v[s]}, 0);
    bsc = sc_cnt[0];
    repeat (20) @(negedge clk);
    chk("idle_no_scan", sc_cnt[0] - bsc, 0);
    // basic load with readback of a preloaded 0xBEEF chain
    preload(0, 16'hBEEF);
    load(0, 8'hA5, 8'h3C, 8'hBE, 8'hEF, 16'hA53C, 16, 19, 0, 1'b0);
    // partial final byte on a 12-bit chain
    preload(1, 16'h0ABC);
    load(1, 8'hFF, 8'h9F, 8'hAB, 8'hC0, 16'h0FF9, 12, 15, 0, 1'b0);
    // 5-cycle stall between bytes plus a stray start mid-load
    preload(0, 16'h1234);
    load(0, 8'h5A, 8'hC3, 8'h12, 8'h34, 16'h5AC3, 16, 24, 5, 1'b1);
    // reset after 5 shift cycles, then a clean reload
    bsc = sc_cnt[0];
    start_v[0] = 1'b1;
    in_data_v[0] = 8'hA5;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (sc_cnt[0] - bsc < 5 && n < 200) begin @(negedge clk); n++; end
    rst = 1'b1;
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst_scan_en", 32'(scan_en_v[0]), 0);
    chk("midrst_busy", 32'(busy_v[0]), 0);
    rst = 1'b0;
    @(negedge clk);
    preload(0, 16'h0F0F);
    load(0, 8'h81, 8'h7E, 8'h0F, 8'h0F, 16'h817E, 16, 19, 0, 1'b0);
    repeat (5) @(negedge clk);
    chk("q16_drained", q0.size(), 0);
    chk("q12_drained", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
